// File: rtl/hps_tx_bridge.sv
// hps_tx_bridge
// Bridges the zezima core's outbound word stream onto the fifo_fpga_to_hps_in
// Avalon-MM write slave. Core words land in a small local FIFO; a three-state
// sequencer issues one Avalon write at a time. A write is only started when the
// HPS FIFO has enough free room, and it is held stable under waitrequest.
// Debug outputs: in_full backpressure, a wrapping accepted-word counter and a
// sticky overflow flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no write outstanding; issue when buffer non-empty and credit ok
// ST_WRITE | avm_write asserted, data held until the slave drops waitrequest
// ST_HOLD  | settle window so csr_fill_level reflects the last accepted word

module hps_tx_bridge #(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int HPS_CAP  = 256,
    parameter int HEADROOM = 4,
    parameter int SETTLE   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_wr,
    input  logic [31:0] in_wdata,
    output logic        in_full,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] csr_fill_level,
    input  logic        clr_ovf,
    output logic [15:0] words_sent,
    output logic        ovf
);

    // Timer holds SETTLE-1 at most; keep it at least one bit wide.
    localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TW-1:0] SETTLE_LD = TW'((SETTLE > 0) ? (SETTLE - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [TW-1:0] timer;

    logic        push;
    logic        pop;
    logic        ok;
    logic        issue;
    logic        accept;
    logic        timer_dec;
    logic [32:0] fill_need;

    assign in_full = (count == (AW + 1)'(DEPTH));
    assign push    = in_wr && !in_full;
    assign pop     = accept;

    // Widened to 33 bits so a garbage fill level near 2^32 cannot wrap into "ok".
    assign fill_need = {1'b0, csr_fill_level} + 33'(HEADROOM);
    assign ok        = (fill_need < 33'(HPS_CAP));

    // Local buffer storage; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_wdata;
        end
    end

    // Buffer pointers and occupancy; a push and pop in one cycle cancel in count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer next-state logic; credit is only consulted before a write starts.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if ((count != '0) && ok) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!avm_waitrequest) begin
                    state_nxt = (SETTLE == 0) ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer control strobes.
    always_comb begin
        issue     = 1'b0;
        accept    = 1'b0;
        timer_dec = 1'b0;
        case (state)
            ST_IDLE:  issue     = (count != '0) && ok;
            ST_WRITE: accept    = !avm_waitrequest;
            ST_HOLD:  timer_dec = (timer != '0);
            default: ;
        endcase
    end

    // Avalon write master: data is latched once at issue and never touched until acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            avm_write     <= 1'b0;
            avm_writedata <= '0;
        end else if (issue) begin
            avm_write     <= 1'b1;
            avm_writedata <= mem[rd_ptr];
        end else if (accept) begin
            avm_write     <= 1'b0;
        end
    end

    // Settle down-counter, loaded when the slave takes a word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (accept) begin
            timer <= SETTLE_LD;
        end else if (timer_dec) begin
            timer <= timer - TW'(1);
        end
    end

    // Accepted-word counter, free-running wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words_sent <= '0;
        end else if (accept) begin
            words_sent <= words_sent + 16'd1;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (in_wr && in_full) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hps_tx_bridge.sv
// tb_hps_tx_bridge
// Directed bench for hps_tx_bridge: latency, stall, throttle, overflow,
// streaming with random waitrequest, and asynchronous reset mid-write.
`timescale 1ns/1ps

module tb_hps_tx_bridge;

    logic        clk;
    logic        rst;
    logic        in_wr;
    logic [31:0] in_wdata;
    logic        in_full;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] csr_fill_level;
    logic        clr_ovf;
    logic [15:0] words_sent;
    logic        ovf;

    int n_chk;
    int n_pass;

    logic [31:0] rx[$];
    logic        hold_prev;
    logic [31:0] hold_data;
    logic        rand_wr;
    logic [15:0] exp_sent;

    hps_tx_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .in_wr           (in_wr),
        .in_wdata        (in_wdata),
        .in_full         (in_full),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .csr_fill_level  (csr_fill_level),
        .clr_ovf         (clr_ovf),
        .words_sent      (words_sent),
        .ovf             (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int g;
        g = 0;
        while (rx.size() < n && g < budget) begin
            tick();
            g++;
        end
        chk(tag, rx.size(), n);
    endtask

    // Acceptance monitor and hold-stability check, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("mon_hold_wr", {31'd0, avm_write}, 32'd1);
                chk("mon_hold_data", avm_writedata, hold_data);
            end
            if (avm_write && !avm_waitrequest) begin
                rx.push_back(avm_writedata);
            end
            hold_prev = avm_write && avm_waitrequest;
            hold_data = avm_writedata;
        end
    end

    // Random waitrequest while streaming.
    always @(posedge clk) begin
        if (rand_wr) begin
            #1;
            avm_waitrequest = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        hold_prev = 1'b0;
        rand_wr = 1'b0;
        exp_sent = 16'd0;
        rst = 1'b0;
        in_wr = 1'b0;
        in_wdata = '0;
        avm_waitrequest = 1'b0;
        csr_fill_level = '0;
        clr_ovf = 1'b0;

        // Reset state
        #23;
        chk("rst_wr", {31'd0, avm_write}, 32'd0);
        chk("rst_data", avm_writedata, 32'd0);
        chk("rst_sent", {16'd0, words_sent}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_full", {31'd0, in_full}, 32'd0);
        rst = 1'b1;
        tick();
        tick();

        // Single word: two-cycle latency, one-cycle write
        rx.delete();
        in_wr = 1'b1; in_wdata = 32'hDEADBEEF;
        tick();
        in_wr = 1'b0;
        chk("lat_e0_wr", {31'd0, avm_write}, 32'd0);
        tick();
        chk("lat_e1_wr", {31'd0, avm_write}, 32'd1);
        chk("lat_e1_data", avm_writedata, 32'hDEADBEEF);
        tick();
        exp_sent++;
        chk("single_wr_drop", {31'd0, avm_write}, 32'd0);
        chk("single_sent", {16'd0, words_sent}, {16'd0, exp_sent});
        tick(); tick(); tick();
        chk("single_rx_n", rx.size(), 1);
        if (rx.size() > 0) chk("single_rx_d", rx[0], 32'hDEADBEEF);

        // Two words back to back: settle gap between writes
        rx.delete();
        in_wr = 1'b1; in_wdata = 32'hA1A1A1A1;
        tick();
        in_wdata = 32'hB2B2B2B2;
        tick();
        in_wr = 1'b0;
        chk("gap_w0", {31'd0, avm_write}, 32'd1);
        chk("gap_d0", avm_writedata, 32'hA1A1A1A1);
        tick();
        chk("gap_e2", {31'd0, avm_write}, 32'd0);
        tick();
        chk("gap_e3", {31'd0, avm_write}, 32'd0);
        tick();
        chk("gap_e4", {31'd0, avm_write}, 32'd0);
        tick();
        chk("gap_w1", {31'd0, avm_write}, 32'd1);
        chk("gap_d1", avm_writedata, 32'hB2B2B2B2);
        tick();
        exp_sent += 2;
        chk("gap_sent", {16'd0, words_sent}, {16'd0, exp_sent});
        tick(); tick(); tick(); tick();

        // Waitrequest stall
        rx.delete();
        avm_waitrequest = 1'b1;
        in_wr = 1'b1; in_wdata = 32'h11111111;
        tick();
        in_wr = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("stall_wr", {31'd0, avm_write}, 32'd1);
            chk("stall_data", avm_writedata, 32'h11111111);
            if (k < 5) tick();
        end
        avm_waitrequest = 1'b0;
        tick();
        exp_sent++;
        chk("stall_release", {31'd0, avm_write}, 32'd0);
        chk("stall_sent", {16'd0, words_sent}, {16'd0, exp_sent});
        chk("stall_rx_n", rx.size(), 1);
        tick(); tick(); tick(); tick();

        // Throttle on HPS fill level
        rx.delete();
        csr_fill_level = 32'd252;
        for (int i = 0; i < 3; i++) begin
            in_wr = 1'b1; in_wdata = 32'hC0DE0000 + i;
            tick();
        end
        in_wr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("thr_block", {31'd0, avm_write}, 32'd0);
            tick();
        end
        csr_fill_level = 32'd251;
        wait_rx(3, 100, "thr_rx_n");
        for (int i = 0; i < 3 && i < rx.size(); i++) begin
            chk("thr_order", rx[i], 32'hC0DE0000 + i);
        end
        chk("thr_full", {31'd0, in_full}, 32'd0);
        tick(); tick(); tick(); tick();
        exp_sent += 3;
        chk("thr_sent", {16'd0, words_sent}, {16'd0, exp_sent});

        // Overflow with a clear in the same cycle as the drop
        rx.delete();
        csr_fill_level = 32'd256;
        chk("ovf_pre", {31'd0, ovf}, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            in_wr = 1'b1; in_wdata = 32'(i);
            tick();
            chk("ovf_full", {31'd0, in_full}, (i == 8) ? 32'd1 : 32'd0);
        end
        in_wdata = 32'd9; clr_ovf = 1'b1;
        tick();
        in_wr = 1'b0; clr_ovf = 1'b0;
        chk("ovf_set_wins", {31'd0, ovf}, 32'd1);
        chk("ovf_no_issue", {31'd0, avm_write}, 32'd0);
        csr_fill_level = 32'd0;
        wait_rx(8, 200, "ovf_rx_n");
        for (int i = 0; i < 8 && i < rx.size(); i++) begin
            chk("ovf_order", rx[i], 32'(i + 1));
        end
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("ovf_rx_final", rx.size(), 8);
        exp_sent += 8;
        chk("ovf_sent", {16'd0, words_sent}, {16'd0, exp_sent});
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", {31'd0, ovf}, 32'd0);

        // Stream 100 words with random waitrequest
        rx.delete();
        rand_wr = 1'b1;
        for (int i = 0; i < 100; i++) begin
            int g;
            g = 0;
            while (in_full && g < 200) begin
                tick();
                g++;
            end
            if (in_full) chk("strm_full_timeout", {31'd0, in_full}, 32'd0);
            in_wr = 1'b1; in_wdata = 32'hA0000000 + i;
            tick();
            in_wr = 1'b0;
            tick(); tick();
        end
        wait_rx(100, 2000, "strm_rx_n");
        rand_wr = 1'b0;
        #1;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 100 && i < rx.size(); i++) begin
            if (rx[i] !== 32'hA0000000 + i) chk("strm_order", rx[i], 32'hA0000000 + i);
        end
        chk("strm_order_last", (rx.size() > 99) ? rx[99] : 32'hX, 32'hA0000063);
        tick(); tick(); tick(); tick(); tick();
        exp_sent += 100;
        chk("strm_sent", {16'd0, words_sent}, {16'd0, exp_sent});
        chk("strm_ovf", {31'd0, ovf}, 32'd0);

        // Async reset in the middle of a stalled write
        rx.delete();
        avm_waitrequest = 1'b1;
        in_wr = 1'b1; in_wdata = 32'h5A5A5A5A;
        tick();
        in_wr = 1'b0;
        tick();
        chk("arst_pre_wr", {31'd0, avm_write}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_wr", {31'd0, avm_write}, 32'd0);
        chk("arst_sent", {16'd0, words_sent}, 32'd0);
        chk("arst_full", {31'd0, in_full}, 32'd0);
        tick();
        rst = 1'b1;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("arst_empty_rx", rx.size(), 0);
        chk("arst_empty_wr", {31'd0, avm_write}, 32'd0);
        chk("arst_sent_after", {16'd0, words_sent}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
